// File: rtl/gpu_10gbetx_snap_capture.sv
// gpu_10gbetx_snap_capture: arms from a software ctrl word, optionally waits for a trigger,
// then writes a fixed-depth burst of TX words into a snapshot BRAM and reports done/count.
module gpu_10gbetx_snap_capture #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic [31:0]           ctrl,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  trig,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic [31:0]           status
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    arm_prev_q;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic [31:0]             status_q, status_d;
    logic                    arm_edge, clear, qual, go, accept;
    assign arm_edge = ctrl[0] & ~arm_prev_q;
    assign clear    = ctrl[3];
    assign qual     = ctrl[2] ? din_valid : 1'b1;
    assign go       = ~ctrl[1] | trig;
    // The ARMED cycle that sees go already offers its din as the first sample.
    assign accept   = ~clear & ~arm_edge & qual &
                      ((state_q == CAPTURE) | ((state_q == ARMED) & go));
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            arm_prev_q <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            arm_prev_q <= ctrl[0];
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            status_q   <= status_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else if (arm_edge)
            state_d = ARMED;
        else if (state_q == ARMED && go)
            state_d = CAPTURE;
        else if (state_q == CAPTURE && accept && count_q == LAST)
            state_d = DONE;
    end
    always_comb begin
        count_d  = (clear | arm_edge) ? '0 : count_q + (ADDR_WIDTH+1)'(accept);
        we_d     = accept;
        addr_d   = accept ? count_q[ADDR_WIDTH-1:0] : addr_q;
        din_d    = accept ? din : din_q;
        status_d = '0;
        status_d[31] = (state_q == DONE);
        status_d[30] = (state_q == ARMED) | (state_q == CAPTURE);
        status_d[ADDR_WIDTH:0] = count_q;
    end
    assign bram_we   = we_q;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign status    = status_q;
endmodule

// File: doc/gpu_10gbetx_snap_capture.md
Name: gpu_10gbetx_snap_capture

Overview:
- Capture controller for the 10GbE TX snapshot.
- Sits directly downstream of the gpu_10gbetxsnap_ctrl software register, whose 32-bit user_data_out drives ctrl.
- On a software arm edge and an optional trigger, writes a fixed-depth burst of TX words into a snapshot BRAM and reports done and word count in a status word for software readback.
- Runs entirely in the user_clk domain.

Parameters:
- ADDR_WIDTH, 11: BRAM address width; capture depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 64: captured word width.

Ports:
- user_clk  in  1  clock for all logic.
- user_rst  in  1  reset; synchronous, active-high.
- ctrl  in  32  control word from the ctrl register. Bit 0 = arm (rising edge), bit 1 = trig_sel (1 = wait for trig), bit 2 = vld_sel (1 = write only when din_valid), bit 3 = clear.
- din  in  DATA_WIDTH  TX data to capture.
- din_valid  in  1  TX data qualifier.
- trig  in  1  external trigger (e.g. start of packet).
- bram_addr  out  ADDR_WIDTH  BRAM write address.
- bram_din  out  DATA_WIDTH  BRAM write data.
- bram_we  out  1  BRAM write enable.
- status  out  32  bit 31 = done, bit 30 = busy (ARMED or CAPTURE), bits [ADDR_WIDTH:0] = words written, other bits 0.

Behaviour:
- Reset values:
  - state = IDLE.
  - bram_we = 0, bram_addr = 0, bram_din = 0.
  - count = 0, status = 0.
  - arm_prev = 1, so an arm bit already high at reset does not start a capture; software must toggle it 0 then 1.
- Edge detect: arm_edge = ctrl[0] & ~arm_prev. arm_prev <= ctrl[0] every cycle.
- qual = vld_sel ? din_valid : 1.
- States:
  - IDLE: no writes. On arm_edge: go to ARMED, count <= 0, done <= 0.
  - ARMED: busy = 1. When (trig_sel == 0 or trig == 1), go to CAPTURE, and the current cycle's din is the first candidate sample (written if qual). With trig_sel = 0 capture therefore begins the cycle after arm_edge.
  - CAPTURE: busy = 1. Each cycle with qual: write din at address count[ADDR_WIDTH-1:0], then count <= count + 1. When the write making count = 2^ADDR_WIDTH is issued, go to DONE.
  - DONE: done = 1, busy = 0, no writes, count holds 2^ADDR_WIDTH. arm_edge behaves as in IDLE.
- Write pipeline: a sample accepted in cycle N appears on bram_din / bram_addr with bram_we = 1 in cycle N+1. bram_we is a single-cycle pulse per accepted sample.
- Addressing: addresses run 0 to 2^ADDR_WIDTH-1 with no wrap. Exactly 2^ADDR_WIDTH writes per capture. count is ADDR_WIDTH+1 bits so full depth is representable.
- Re-arm:
  - arm_edge in ARMED or CAPTURE restarts: state ARMED, count <= 0, done <= 0.
  - A write already in the output pipeline still completes the cycle after the restart.
- Clear: ctrl[3] = 1 forces IDLE, count <= 0, done <= 0, and suppresses any new write. Clear has priority over arm_edge and trig in the same cycle.
- Trigger edge cases:
  - trig while IDLE or DONE is ignored.
  - trig during CAPTURE has no effect.
- Reset mid-capture: user_rst asserted in any state returns all outputs to reset values on the next edge. The pipelined write is dropped (bram_we = 0).
- status is registered and updates one cycle after state/count change.

Test Plan:
- Reset with ctrl = 0x1 held, then 100 cycles -> bram_we never asserted, status = 0. Then ctrl 0x0 -> 0x1 -> busy = 1 next cycle, captures start.
- ADDR_WIDTH = 4, ctrl = 0x1 edge, trig_sel = 0, vld_sel = 0, din = cycle count -> exactly 16 bram_we pulses at addresses 0..15, data consecutive, then status = 0x80000010.
- ctrl = 0x3 edge, trig pulsed at cycle 20 with din = 0xA5 -> first write at cycle 21, address 0, data 0xA5. No writes before the trigger.
- ctrl = 0x5, din_valid toggling 1,0,1,0 -> writes only on valid cycles, addresses contiguous, 16 writes take 32 cycles.
- Mid-capture at count = 7, assert ctrl[3] together with an arm edge -> IDLE, status = 0, no further writes. Then a fresh arm edge -> capture restarts at address 0.
- user_rst pulsed at count = 9 -> next cycle bram_we = 0 and status = 0, and no capture occurs until a new arm edge.
